plab3_mem_partitioned_mem_responder: RTL and testbench

//  Main-memory responder at the memory side of the L2 blocking cache: accepts

---
 rtl/plab3_mem_partitioned_mem_responder_pkg.sv | 33 +++
 rtl/plab3_mem_partitioned_mem_array.sv | 39 +++
 rtl/plab3_mem_partitioned_mem_responder.sv | 145 ++++++++++++++
 tb/tb_plab3_mem_partitioned_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/plab3_mem_partitioned_mem_responder_pkg.sv
// Shared message layout, memreq type codes and controller states for the
// partitioned main-memory responder.
package plab3_mem_partitioned_mem_responder_pkg;

    localparam int unsigned ABW        = 32;
    localparam int unsigned CLW        = 128;
    localparam int unsigned BE_NBITS   = CLW / 8;
    localparam int unsigned TYPE_NBITS = 3;
    localparam int unsigned LEN_NBITS  = 4;

    // Message widths excluding the opaque field, which is sized by the top.
    localparam int unsigned REQ_FIXED_NBITS  = TYPE_NBITS + ABW + LEN_NBITS + CLW;
    localparam int unsigned RESP_FIXED_NBITS = TYPE_NBITS + LEN_NBITS + CLW;

    localparam logic [TYPE_NBITS-1:0] VC_MEM_REQ_MSG_TYPE_READ  = 3'd0;
    localparam logic [TYPE_NBITS-1:0] VC_MEM_REQ_MSG_TYPE_WRITE = 3'd1;
    localparam logic [TYPE_NBITS-1:0] VC_MEM_REQ_MSG_TYPE_INIT  = 3'd2;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WAIT,
        STATE_RESP
    } state_t;

    // len==0 means a full line; otherwise the low len bytes are written.
    function automatic logic [BE_NBITS-1:0] len_to_be(input logic [LEN_NBITS-1:0] len);
        if (len == '0) begin
            return '1;
        end
        return (BE_NBITS'(1) << len) - BE_NBITS'(1);
    endfunction

endpackage

// File: rtl/plab3_mem_partitioned_mem_array.sv
// Line storage for two security domains: combinational read, byte-enable
// synchronous write. The physical line is {sd, index}.
module plab3_mem_partitioned_mem_array
    import plab3_mem_partitioned_mem_responder_pkg::*;
#(
    parameter int unsigned p_nlines = 128,
    parameter int unsigned p_clw    = CLW,
    localparam int unsigned IW      = $clog2(p_nlines)
) (
    input  logic                 clk,
    input  logic                 sd_i,
    input  logic [IW-1:0]        idx_i,
    output logic [p_clw-1:0]     rdata_o,
    input  logic                 wen_i,
    input  logic [p_clw/8-1:0]   wbe_i,
    input  logic [p_clw-1:0]     wdata_i
);

    logic [p_clw-1:0] mem_q [2*p_nlines];
    logic [p_clw-1:0] wmask;
    logic [IW:0]      line;

    assign line = {sd_i, idx_i};

    for (genvar b = 0; b < p_clw / 8; b++) begin : g_mask
        assign wmask[b*8 +: 8] = {8{wbe_i[b]}};
    end

    always_comb begin
        rdata_o = mem_q[line];
    end

    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[line] <= (mem_q[line] & ~wmask) | (wdata_i & wmask);
        end
    end

endmodule

// File: rtl/plab3_mem_partitioned_mem_responder.sv
// Fixed-latency main-memory responder for the L2 memreq/memresp interface,
// with storage partitioned by the security domain latched at accept.
module plab3_mem_partitioned_mem_responder
    import plab3_mem_partitioned_mem_responder_pkg::*;
#(
    parameter int unsigned p_mem_nbytes   = 4096,
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_latency      = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [REQ_FIXED_NBITS+p_opaque_nbits-1:0]    memreq_msg,
    input  logic                                         memreq_val,
    output logic                                         memreq_rdy,
    output logic [RESP_FIXED_NBITS+p_opaque_nbits-1:0]   memresp_msg,
    output logic                                         memresp_val,
    input  logic                                         memresp_rdy,
    input  logic                                         sd
);

    localparam int unsigned NLINES   = (p_mem_nbytes / 2) / (CLW / 8);
    localparam int unsigned IDX_W    = $clog2(NLINES);
    localparam int unsigned CNT_W    = (p_latency > 1) ? $clog2(p_latency) : 1;
    localparam int unsigned LEN_LSB  = CLW;
    localparam int unsigned ADDR_LSB = LEN_LSB + LEN_NBITS;
    localparam int unsigned OPQ_LSB  = ADDR_LSB + ABW;
    localparam int unsigned TYPE_LSB = OPQ_LSB + p_opaque_nbits;

    state_t state_q, state_d;

    logic [CNT_W-1:0]          cnt_q;
    logic [TYPE_NBITS-1:0]     type_q;
    logic [p_opaque_nbits-1:0] opaque_q;
    logic [ABW-1:0]            addr_q;
    logic [LEN_NBITS-1:0]      len_q;
    logic [CLW-1:0]            data_q;
    logic                      sd_q;
    logic [CLW-1:0]            rdata_q;
    logic                      err_q;

    logic [TYPE_NBITS-1:0]     req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [ABW-1:0]            req_addr;
    logic [LEN_NBITS-1:0]      req_len;
    logic [CLW-1:0]            req_data;

    logic           accept;
    logic           wait_done;
    logic           is_store;
    logic           arr_wen;
    logic [CLW-1:0] arr_rdata;
    logic           unused_addr_err;

    assign req_type   = memreq_msg[TYPE_LSB +: TYPE_NBITS];
    assign req_opaque = memreq_msg[OPQ_LSB  +: p_opaque_nbits];
    assign req_addr   = memreq_msg[ADDR_LSB +: ABW];
    assign req_len    = memreq_msg[LEN_LSB  +: LEN_NBITS];
    assign req_data   = memreq_msg[0        +: CLW];

    assign accept    = (state_q == STATE_IDLE) && memreq_val;
    assign wait_done = (state_q == STATE_WAIT) && (cnt_q == CNT_W'(p_latency - 1));
    assign is_store  = (type_q == VC_MEM_REQ_MSG_TYPE_WRITE) ||
                       (type_q == VC_MEM_REQ_MSG_TYPE_INIT);

    // Stores land on the first WAIT cycle so a following read always sees them;
    // a reset in that cycle abandons the store along with the transaction.
    assign arr_wen = (state_q == STATE_WAIT) && (cnt_q == '0) && is_store && !reset;

    assign unused_addr_err = ^{addr_q[3:0], addr_q[ABW-1:IDX_W+4], err_q};

    plab3_mem_partitioned_mem_array #(
        .p_nlines (NLINES),
        .p_clw    (CLW)
    ) u_array (
        .clk     (clk),
        .sd_i    (sd_q),
        .idx_i   (addr_q[IDX_W+3:4]),
        .rdata_o (arr_rdata),
        .wen_i   (arr_wen),
        .wbe_i   (len_to_be(len_q)),
        .wdata_i (data_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_IDLE: if (memreq_val)  state_d = STATE_WAIT;
            STATE_WAIT: if (wait_done)   state_d = STATE_RESP;
            STATE_RESP: if (memresp_rdy) state_d = STATE_IDLE;
            default:                     state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        memreq_rdy  = (state_q == STATE_IDLE);
        memresp_val = (state_q == STATE_RESP);
        memresp_msg = '0;
        if (state_q == STATE_RESP) begin
            memresp_msg = {type_q, opaque_q, {LEN_NBITS{1'b0}}, rdata_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            type_q   <= '0;
            opaque_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            sd_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                type_q   <= req_type;
                opaque_q <= req_opaque;
                addr_q   <= req_addr;
                len_q    <= req_len;
                data_q   <= req_data;
                sd_q     <= sd;
                if (req_type != VC_MEM_REQ_MSG_TYPE_READ &&
                    req_type != VC_MEM_REQ_MSG_TYPE_WRITE &&
                    req_type != VC_MEM_REQ_MSG_TYPE_INIT) begin
                    err_q <= 1'b1;
                end
            end else if (state_q == STATE_WAIT) begin
                cnt_q <= wait_done ? '0 : cnt_q + 1'b1;
            end
            if (wait_done) begin
                rdata_q <= (type_q == VC_MEM_REQ_MSG_TYPE_READ) ? arr_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_plab3_mem_partitioned_mem_responder.sv
// Directed bench for the partitioned memory responder: fixed latency,
// byte enables, partition isolation, address wrap, stalls and mid-flight reset.
module tb_plab3_mem_partitioned_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [174:0] memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    logic [142:0] memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;
    logic         sd;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] D1 = 128'hDEADBEEF_12345678_9ABCDEF0_00000001;
    localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] D4 = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;
    localparam logic [127:0] D5 = 128'h13579BDF_2468ACE0_11223344_55667788;
    localparam logic [127:0] ONES = '1;

    plab3_mem_partitioned_mem_responder #(
        .p_mem_nbytes   (4096),
        .p_opaque_nbits (8),
        .p_latency      (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .sd          (sd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [142:0] obs, input logic [142:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [142:0] rmsg(input logic [2:0] t, input logic [7:0] o,
                                          input logic [127:0] d);
        return {t, o, 4'h0, d};
    endfunction

    // One request/response; sd is flipped after accept to show the latched
    // domain is the one used. Holds memresp_rdy low for 'stall' cycles.
    task automatic txn(input string tag, input logic [2:0] t, input logic [7:0] o,
                       input logic [31:0] a, input logic [3:0] l, input logic [127:0] d,
                       input logic s, input int stall, input bit keep, input bit chk,
                       input logic [142:0] exp, output logic [142:0] got);
        int lat;
        memresp_rdy = (stall == 0);
        check({tag, ".req_rdy"}, memreq_rdy, 1'b1);
        memreq_msg = {t, o, a, l, d};
        sd         = s;
        memreq_val = 1'b1;
        tick();
        memreq_val = keep;
        sd         = ~s;
        lat = 0;
        while (!memresp_val && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 4);
        got = memresp_msg;
        if (chk) check({tag, ".msg"}, got, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, ".hold_val"}, memresp_val, 1'b1);
            check({tag, ".hold_msg"}, memresp_msg, got);
            check({tag, ".hold_rdy"}, memreq_rdy, 1'b0);
        end
        memresp_rdy = 1'b1;
        tick();
        check({tag, ".idle_rdy"}, memreq_rdy, 1'b1);
        check({tag, ".idle_val"}, memresp_val, 1'b0);
        memreq_val = 1'b0;
    endtask

    initial begin
        logic [142:0] got;
        logic         seen;

        reset       = 1'b1;
        memreq_msg  = '0;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        sd          = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst.req_rdy", memreq_rdy, 1'b1);
        check("rst.resp_val", memresp_val, 1'b0);
        check("rst.resp_msg", memresp_msg, '0);
        check("rst.err", dut.err_q, 1'b0);

        // Full-line write, then read back with ignored low address bits.
        txn("t1.wr", 3'd1, 8'h11, 32'h100, 4'd0, D1, 1'b0, 0, 0, 1, rmsg(3'd1, 8'h11, '0), got);
        txn("t2.rd", 3'd0, 8'h22, 32'h10C, 4'd0, '0, 1'b0, 0, 0, 1, rmsg(3'd0, 8'h22, D1), got);

        txn("t2.iso", 3'd0, 8'h23, 32'h100, 4'd0, '0, 1'b1, 0, 0, 0, '0, got);
        total++;
        assert (got[127:0] !== D1) else begin
            bad++;
            $error("FAIL t2.iso_data: observed=%h expected=not %h", got[127:0], D1);
        end
        txn("t2.wr1", 3'd1, 8'h24, 32'h100, 4'd0, D2, 1'b1, 0, 0, 1, rmsg(3'd1, 8'h24, '0), got);
        txn("t2.rd0", 3'd0, 8'h25, 32'h100, 4'd0, '0, 1'b0, 0, 0, 1, rmsg(3'd0, 8'h25, D1), got);
        txn("t2.rd1", 3'd0, 8'h26, 32'h100, 4'd0, '0, 1'b1, 0, 0, 1, rmsg(3'd0, 8'h26, D2), got);

        // Partial writes via len byte enables.
        txn("t3.fill", 3'd1, 8'h31, 32'h200, 4'd0, ONES, 1'b0, 0, 0, 1, rmsg(3'd1, 8'h31, '0), got);
        txn("t3.wr4", 3'd1, 8'h32, 32'h200, 4'd4, 128'h11111111_22222222_33333333_CAFEF00D,
            1'b0, 0, 0, 1, rmsg(3'd1, 8'h32, '0), got);
        txn("t3.rd4", 3'd0, 8'h33, 32'h200, 4'd0, '0, 1'b0, 0, 0, 1,
            rmsg(3'd0, 8'h33, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_CAFEF00D), got);
        txn("t3.clr", 3'd1, 8'h34, 32'h280, 4'd0, '0, 1'b0, 0, 0, 1, rmsg(3'd1, 8'h34, '0), got);
        txn("t3.wr15", 3'd1, 8'h35, 32'h280, 4'd15, ONES, 1'b0, 0, 0, 1, rmsg(3'd1, 8'h35, '0), got);
        txn("t3.rd15", 3'd0, 8'h36, 32'h280, 4'd0, '0, 1'b0, 0, 0, 1,
            rmsg(3'd0, 8'h36, 128'h00FFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF), got);

        // Long response stall with a new request waiting during the handshake.
        txn("t4.stall", 3'd0, 8'h44, 32'h200, 4'd0, '0, 1'b0, 10, 1, 1,
            rmsg(3'd0, 8'h44, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_CAFEF00D), got);
        txn("t4.next", 3'd0, 8'h45, 32'h100, 4'd0, '0, 1'b1, 0, 0, 1, rmsg(3'd0, 8'h45, D2), got);

        // Interleaved domains with random stalls; 0x820 wraps onto 0x20.
        txn("t5.wr0", 3'd1, 8'h51, 32'h020, 4'd0, D4, 1'b0, $urandom_range(0, 3), 0, 1,
            rmsg(3'd1, 8'h51, '0), got);
        txn("t5.wr1", 3'd1, 8'h52, 32'h820, 4'd0, D3, 1'b1, $urandom_range(0, 3), 0, 1,
            rmsg(3'd1, 8'h52, '0), got);
        txn("t5.rd0", 3'd0, 8'h53, 32'h020, 4'd0, '0, 1'b0, $urandom_range(0, 3), 0, 1,
            rmsg(3'd0, 8'h53, D4), got);
        txn("t5.rd1", 3'd0, 8'h54, 32'h020, 4'd0, '0, 1'b1, $urandom_range(0, 3), 0, 1,
            rmsg(3'd0, 8'h54, D3), got);
        txn("t5.alias", 3'd0, 8'h55, 32'h820, 4'd0, '0, 1'b0, $urandom_range(0, 3), 0, 1,
            rmsg(3'd0, 8'h55, D4), got);
        txn("t5.init", 3'd2, 8'h56, 32'h300, 4'd0, D5, 1'b1, $urandom_range(0, 3), 0, 1,
            rmsg(3'd2, 8'h56, '0), got);
        txn("t5.rdi", 3'd0, 8'h57, 32'h300, 4'd0, '0, 1'b1, $urandom_range(0, 3), 0, 1,
            rmsg(3'd0, 8'h57, D5), got);

        // Unsupported type: echoed, no data, no store, error flag raised.
        txn("amo", 3'd3, 8'h5A, 32'h100, 4'd0, ONES, 1'b0, 0, 0, 1, rmsg(3'd3, 8'h5A, '0), got);
        check("amo.err", dut.err_q, 1'b1);

        // Reset while the request is in WAIT.
        check("t6.req_rdy", memreq_rdy, 1'b1);
        memreq_msg = {3'd0, 8'h61, 32'h100, 4'd0, 128'h0};
        sd         = 1'b0;
        memreq_val = 1'b1;
        tick();
        memreq_val = 1'b0;
        check("t6.in_wait", memreq_rdy, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6.rst_rdy", memreq_rdy, 1'b1);
        check("t6.rst_val", memresp_val, 1'b0);
        check("t6.rst_msg", memresp_msg, '0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (memresp_val) seen = 1'b1;
        end
        check("t6.no_resp", seen, 1'b0);
        txn("t6.rd", 3'd0, 8'h62, 32'h100, 4'd0, '0, 1'b0, 0, 0, 1, rmsg(3'd0, 8'h62, D1), got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
